pp_accum_mul: RTL and testbench
===============================

Name: pp_accum_mul

Overview:
- Sequential WIDTH x WIDTH unsigned multiplier for the FIR datapath.
- Contains exactly one mul_2bit instance. Each cycle it drives one 2-bit digit of each operand into it.
- Shifts and accumulates the 4-bit digit products into a 2*WIDTH-bit result.
- Sits directly downstream of mul_2bit: consumes its r output. Trades area for latency versus a full array multiplier in the tap datapath.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4; DIGITS = WIDTH/2; a multiply takes DIGITS*DIGITS RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  multiplicand (unsigned), sampled on accept
- b  input  WIDTH  multiplier (unsigned), sampled on accept
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- product  output  2*WIDTH  a*b result
- out_valid  output  1  product valid
- out_ready  input  1  consumer takes product
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset: one clock; rst_n asynchronous, active-low. On assertion, immediately: state=IDLE, product=0, out_valid=0, in_ready=1, busy=0; operand registers, accumulator and digit counters i,j cleared.
- Reset mid-operation aborts the multiply; the result is discarded; no out_valid pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept on clk edge with in_valid=1: latch a_r=a, b_r=b, acc=0, i=0, j=0 -> RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0.
  - mul_2bit inputs: p1p0=a_r[2i+1:2i], q1q0=b_r[2j+1:2j].
  - Each edge: acc <= acc + (r zero-extended to 2*WIDTH, shifted left by 2*(i+j)).
  - j increments; on j=DIGITS-1, j wraps to 0 and i increments.
  - On the edge where i=j=DIGITS-1: product <= acc + final shifted term; out_valid <= 1 -> DONE.
  - in_valid during RUN is ignored; no queuing.
- DONE:
  - out_valid=1; product held stable; in_ready=0.
  - Edge with out_ready=1: out_valid <= 0 -> IDLE. product keeps its value (not cleared) until the next completion.
  - out_ready=0: hold indefinitely (backpressure).
- Latency: operands accepted on edge T0 -> out_valid high after edge T0+DIGITS^2 (16 for WIDTH=8).
- Throughput: the earliest next accept is the edge after the handshake-out edge, so one multiply per DIGITS^2+2 cycles.
- Arithmetic: all unsigned. acc is 2*WIDTH bits; the maximum product (2^WIDTH-1)^2 fits, so no overflow or wrap is possible.
- Simultaneous in_valid=1 and out_ready=1 in DONE: only the output handshake completes; in_valid is not accepted on that edge (in_ready=0).
- out_valid never deasserts without out_ready; product never changes while out_valid=1.

Test Plan:
1. Reset, then a=0x5A, b=0xC3, in_valid pulse, out_ready=1 -> out_valid rises exactly 16 cycles after accept, product=0x448E; then in_ready=1 on the following cycle.
2. a=0xFF, b=0xFF -> product=0xFE01; a=0x00, b=0xA7 -> product=0x0000; a=0x80, b=0x02 -> product=0x0100 (exercises the top and bottom digit shifts).
3. Backpressure: a=0x12, b=0x34; hold out_ready=0 for 5 cycles after out_valid -> out_valid stays 1, product=0x03A8 stable; release -> out_valid drops after one edge, state returns to IDLE.
4. Hold in_valid=1 continuously with new operands (a=0x0F, b=0x0F) changing to (a=0xAA, b=0x55) while in RUN -> first result=0x00E1 (the RUN-phase change is ignored); the second accept occurs only after the output handshake and yields product=0x3872.
5. Assert rst_n=0 asynchronously 7 cycles into a RUN with a=0xFF, b=0xFF -> all outputs go to reset values immediately (no clock edge needed); no out_valid afterwards; a subsequent a=0x03, b=0x05 gives 0x000F.
6. Randomised sweep of 1000 operand pairs with random out_ready gaps -> every product equals a*b and every latency equals 16.

Source files
------------

// File: rtl/pp_accum_mul.sv
// Sequential unsigned multiplier: one 2-bit x 2-bit digit product per cycle,
// shifted and accumulated into a 2*WIDTH-bit result with a valid/ready interface.

module mul_2bit (
  input  logic [1:0] p1p0,
  input  logic [1:0] q1q0,
  output logic [3:0] r
);
  assign r = {2'b00, p1p0} * {2'b00, q1q0};
endmodule

module pp_accum_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);
  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = $clog2(DIGITS);
  localparam int PW     = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] a_r, b_r;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    i, j;
  logic [1:0]       digit_a, digit_b;
  logic [3:0]       r;
  logic [CW+1:0]    shamt;
  logic [PW-1:0]    term;
  logic             last_j, last;

  assign digit_a = a_r[2*i +: 2];
  assign digit_b = b_r[2*j +: 2];

  mul_2bit u_mul (
    .p1p0 (digit_a),
    .q1q0 (digit_b),
    .r    (r)
  );

  // Digit weight is 4^(i+j): shift by twice the digit-index sum.
  assign shamt  = {({1'b0, i} + {1'b0, j}), 1'b0};
  assign term   = PW'(r) << shamt;
  assign last_j = (j == CW'(DIGITS - 1));
  assign last   = last_j && (i == CW'(DIGITS - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      i       <= '0;
      j       <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
            acc <= '0;
            i   <= '0;
            j   <= '0;
          end
        end
        RUN: begin
          acc <= acc + term;
          if (last_j) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
          if (last) product <= acc + term;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pp_accum_mul.sv
// Self-checking bench for pp_accum_mul: directed scenarios plus a randomised
// sweep compared against plain a*b and a fixed DIGITS^2 latency.

module tb_pp_accum_mul;
  localparam int WIDTH   = 8;
  localparam int DIGITS  = WIDTH / 2;
  localparam int LATENCY = DIGITS * DIGITS;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [WIDTH-1:0]   a, b;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] product;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int checks = 0;
  int errors = 0;

  pp_accum_mul #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int unsigned p;
    p = int'(x) * int'(y);
    return p[2*WIDTH-1:0];
  endfunction

  // Wait for out_valid after an accept edge; returns edges elapsed or -1 on timeout.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  // One full transaction: accept, wait, check, hold for 'gap' cycles, handshake.
  task automatic do_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int gap, input string name);
    int lat;
    logic [2*WIDTH-1:0] exp_p;
    exp_p = ref_mul(x, y);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready_before_accept: got %b want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat);
    checks++;
    if (lat != LATENCY) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, LATENCY);
    end
    checks++;
    if (product !== exp_p) begin
      errors++;
      $display("FAIL %s product: got %h want %h (a=%h b=%h)", name, product, exp_p, x, y);
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || product !== exp_p || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold: out_valid=%b product=%h in_ready=%b want 1/%h/0", name, out_valid, product, in_ready, exp_p);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || product !== exp_p) begin
      errors++;
      $display("FAIL %s handshake: out_valid=%b in_ready=%b busy=%b product=%h want 0/1/0/%h", name, out_valid, in_ready, busy, product, exp_p);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (product !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: product=%h out_valid=%b in_ready=%b busy=%b want 0/0/1/0", product, out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_mul(8'h5A, 8'hC3, 0, "basic_5A_C3");
    checks++;
    if (ref_mul(8'h5A, 8'hC3) !== 16'h448E) begin
      errors++;
      $display("FAIL basic_ref_model: got %h want 448e", ref_mul(8'h5A, 8'hC3));
    end
  endtask

  task automatic test_corners();
    do_mul(8'hFF, 8'hFF, 0, "corner_FF_FF");
    do_mul(8'h00, 8'hA7, 1, "corner_00_A7");
    do_mul(8'h80, 8'h02, 0, "corner_80_02");
  endtask

  task automatic test_backpressure();
    do_mul(8'h12, 8'h34, 5, "backpressure");
  endtask

  task automatic test_in_valid_held();
    int lat;
    a = 8'h0F; b = 8'h0F; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    a = 8'hAA; b = 8'h55;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL held_run_flags: in_ready=%b busy=%b want 0/1", in_ready, busy);
    end
    for (int c = 4; c <= 100; c++) begin
      @(posedge clk); #1;
      lat = c;
      if (out_valid === 1'b1) break;
    end
    checks++;
    if (out_valid !== 1'b1 || lat != LATENCY || product !== 16'h00E1) begin
      errors++;
      $display("FAIL held_first: out_valid=%b lat=%0d product=%h want 1/%0d/00e1", out_valid, lat, product, LATENCY);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL held_no_accept_on_handshake: in_ready=%b busy=%b out_valid=%b want 1/0/0", in_ready, busy, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat);
    checks++;
    if (lat != LATENCY || product !== 16'h3872) begin
      errors++;
      $display("FAIL held_second: lat=%0d product=%h want %0d/3872", lat, product, LATENCY);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int seen;
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (product !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: product=%h out_valid=%b in_ready=%b busy=%b want 0/0/1/0", product, out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_out_valid: saw %0d valid cycles want 0", seen);
    end
    out_ready = 1'b0;
    do_mul(8'h03, 8'h05, 0, "after_reset_03_05");
  endtask

  task automatic test_random();
    for (int n = 0; n < 1000; n++) begin
      do_mul(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_in_valid_held();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
